// File: rtl/inst_fetch.sv
// Fetch stage: holds the PC, issues one instruction-memory request at a time and
// presents each returned word to decode through a registered slot backed by a one-entry skid buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        hold,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 7;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_BLOCK = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, pc_nxt;
    logic              valid_nxt;
    logic [XLEN-1:0]   inst_nxt, inst_pc_nxt;
    logic              skid_valid, skid_valid_nxt;
    logic [XLEN-1:0]   skid_inst, skid_inst_nxt;
    logic [XLEN-1:0]   skid_pc, skid_pc_nxt;

    logic              issue;
    logic              xfer;
    logic              rdata_is_cf;
    logic [OPW-1:0]    rdata_op;
    logic              unused_redirect_lsbs;

    // A request goes out only when there is room to park its response.
    assign issue       = (state == S_REQ) && !skid_valid && !redirect && !reset;
    assign xfer        = inst_valid && !hold;
    assign rdata_op    = imem_rdata[OPW-1:0];
    assign rdata_is_cf = (rdata_op == OP_BRANCH) || (rdata_op == OP_JAL) || (rdata_op == OP_JALR);

    assign imem_req             = issue;
    assign imem_addr            = pc;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            skid_valid <= 1'b0;
            skid_inst  <= NOP_INST;
            skid_pc    <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_valid <= valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            skid_valid <= skid_valid_nxt;
            skid_inst  <= skid_inst_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    // Next-state, slot and skid-buffer logic.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        valid_nxt      = inst_valid;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        skid_valid_nxt = skid_valid;
        skid_inst_nxt  = skid_inst;
        skid_pc_nxt    = skid_pc;

        if (xfer) begin
            if (skid_valid) begin
                valid_nxt      = 1'b1;
                inst_nxt       = skid_inst;
                inst_pc_nxt    = skid_pc;
                skid_valid_nxt = 1'b0;
            end else begin
                valid_nxt = 1'b0;
                inst_nxt  = NOP_INST;
            end
        end

        case (state)
            S_REQ: begin
                if (issue) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = rdata_is_cf ? S_BLOCK : S_REQ;
                    // Slot is free (empty or being consumed): fill it, else park the word.
                    if (!valid_nxt) begin
                        valid_nxt   = 1'b1;
                        inst_nxt    = imem_rdata;
                        inst_pc_nxt = pc;
                    end else begin
                        skid_valid_nxt = 1'b1;
                        skid_inst_nxt  = imem_rdata;
                        skid_pc_nxt    = pc;
                    end
                end
            end
            S_BLOCK: begin
                state_nxt = S_BLOCK;
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // Redirect wins over everything; an in-flight response must still be drained.
        if (redirect) begin
            pc_nxt         = {redirect_pc[XLEN-1:2], 2'b00};
            valid_nxt      = 1'b0;
            inst_nxt       = NOP_INST;
            skid_valid_nxt = 1'b0;
            if (state == S_WAIT) begin
                state_nxt = imem_valid ? S_REQ : S_DRAIN;
            end else if (state != S_DRAIN) begin
                state_nxt = S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle table for the basic stream, directed multi-cycle
// sequences, and a randomized run checked against a program-order model.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, hold, redirect, imem_valid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;

    logic        reset2, hold2, redirect2, imem_valid2;
    logic [31:0] redirect_pc2, imem_rdata2;
    logic        imem_req2, inst_valid2;
    logic [31:0] imem_addr2, inst2, inst_pc2;

    inst_fetch u_dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .hold(hold),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
        .clock(clock), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid2), .imem_rdata(imem_rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .hold(hold2),
        .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2)
    );

    // staged inputs, applied just after each rising edge
    bit          s_reset, s_hold, s_redirect, s_reset2, s_valid2;
    logic [31:0] s_rpc, s_rdata2;

    int          n_checks, n_errors;
    int          mem_cnt, lat;
    logic [31:0] mem_addr, seed;
    bit          rand_mode, rand_lat;
    logic [31:0] req_log[$];
    logic [31:0] xfer_log[$];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        if (!rand_mode) return (a == 32'h8) ? 32'h0000_0063 : {a[11:0], 20'h00013};
        h = (a ^ seed) * 32'h9E37_79B1;
        if (h[31:29] == 3'd0) begin
            case (h[3:2])
                2'd2:    return {h[26:2], 7'h6F};
                2'd3:    return {h[26:2], 7'h67};
                default: return {h[26:2], 7'h63};
            endcase
        end
        return {h[26:2], 7'h13};
    endfunction

    function automatic bit is_cf(input logic [31:0] w);
        return (w[6:0] == 7'h63) || (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: apply inputs, run the memory model, sample at the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
        reset = s_reset; hold = s_hold; redirect = s_redirect; redirect_pc = s_rpc;
        reset2 = s_reset2; imem_valid2 = s_valid2; imem_rdata2 = s_rdata2;
        if (s_reset) begin
            mem_cnt = 0;
            imem_valid = 1'b0;
        end else if (mem_cnt == 1) begin
            imem_valid = 1'b1;
            imem_rdata = word_at(mem_addr);
            mem_cnt = 0;
        end else begin
            imem_valid = 1'b0;
            if (mem_cnt > 1) mem_cnt--;
        end
        @(negedge clock);
        if (imem_req) begin
            chk("one_outstanding", {31'b0, (mem_cnt != 0) || imem_valid}, 32'h0);
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
            req_log.push_back(imem_addr);
            mem_addr = imem_addr;
            mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : lat;
        end
        if (inst_valid && !hold) xfer_log.push_back(inst_pc);
    endtask

    task automatic do_reset();
        s_reset = 1'b1; s_hold = 1'b0; s_redirect = 1'b0; s_rpc = 32'h0;
        step();
        step();
        s_reset = 1'b0;
        req_log.delete();
        xfer_log.delete();
    endtask

    typedef struct {
        bit          rst, hld, rdr;
        logic [31:0] rpc;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_v;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[13];

    task automatic row(input int i, input bit rst, input bit hld, input bit rdr, input logic [31:0] rpc,
                       input bit er, input logic [31:0] ea, input bit ev, input logic [31:0] ep);
        tbl[i].rst = rst; tbl[i].hld = hld; tbl[i].rdr = rdr; tbl[i].rpc = rpc;
        tbl[i].e_req = er; tbl[i].e_addr = ea; tbl[i].e_v = ev; tbl[i].e_pc = ep;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_req, exp_x, rd_tgt, prev_inst, prev_pc, w;
        bit          blocked, prev_hv;
        int          rd_cnt, idle, nx, n;

        n_checks = 0; n_errors = 0; mem_cnt = 0; lat = 1; mem_addr = 32'h0; seed = 32'h0;
        rand_mode = 1'b0; rand_lat = 1'b0;
        reset = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_valid = 1'b0; imem_rdata = 32'h0;
        reset2 = 1'b1; hold2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        imem_valid2 = 1'b0; imem_rdata2 = 32'h0;
        s_reset2 = 1'b1; s_valid2 = 1'b0; s_rdata2 = 32'h0;

        // latency-1 stream, beq at 0x8, redirect to 0x40
        row(0,  Y, N, N, 32'h0,  N, 32'h0,  N, 32'h0);
        row(1,  N, N, N, 32'h0,  Y, 32'h0,  N, 32'h0);
        row(2,  N, N, N, 32'h0,  N, 32'h0,  N, 32'h0);
        row(3,  N, N, N, 32'h0,  Y, 32'h4,  Y, 32'h0);
        row(4,  N, N, N, 32'h0,  N, 32'h4,  N, 32'h0);
        row(5,  N, N, N, 32'h0,  Y, 32'h8,  Y, 32'h4);
        row(6,  N, N, N, 32'h0,  N, 32'h8,  N, 32'h0);
        row(7,  N, N, N, 32'h0,  N, 32'hC,  Y, 32'h8);
        row(8,  N, N, N, 32'h0,  N, 32'hC,  N, 32'h0);
        row(9,  N, N, Y, 32'h40, N, 32'hC,  N, 32'h0);
        row(10, N, N, N, 32'h0,  Y, 32'h40, N, 32'h0);
        row(11, N, N, N, 32'h0,  N, 32'h40, N, 32'h0);
        row(12, N, N, N, 32'h0,  Y, 32'h44, Y, 32'h40);

        s_reset = 1'b1;
        step();
        step();
        for (int i = 0; i < 13; i++) begin
            s_reset = tbl[i].rst; s_hold = tbl[i].hld; s_redirect = tbl[i].rdr; s_rpc = tbl[i].rpc;
            step();
            chk($sformatf("t1 row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("t1 row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("t1 row%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, tbl[i].e_v});
            chk($sformatf("t1 row%0d inst", i), inst, tbl[i].e_v ? word_at(tbl[i].e_pc) : NOP);
            if (tbl[i].e_v || tbl[i].rst)
                chk($sformatf("t1 row%0d inst_pc", i), inst_pc, tbl[i].e_pc);
        end

        // hold from the first valid instruction for 6 cycles
        lat = 1;
        do_reset();
        s_hold = 1'b1;
        n = 0;
        while (!inst_valid && n < 10) begin step(); n++; end
        chk("t3 first_valid", {31'b0, inst_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3 frozen_valid", {31'b0, inst_valid}, 32'h1);
            chk("t3 frozen_pc", inst_pc, 32'h0);
            chk("t3 frozen_inst", inst, word_at(32'h0));
        end
        chk("t3 req_count", 32'(req_log.size()), 32'd2);
        if (req_log.size() >= 2) chk("t3 second_req", req_log[1], 32'h4);
        s_hold = 1'b0;
        req_log.delete();
        xfer_log.delete();
        repeat (6) step();
        chk("t3 xfer_count", {31'b0, xfer_log.size() >= 2}, 32'h1);
        if (xfer_log.size() >= 2) begin
            chk("t3 xfer0", xfer_log[0], 32'h0);
            chk("t3 xfer1", xfer_log[1], 32'h4);
        end
        chk("t3 resume_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h8);

        // redirect to 0x103 while a latency-3 response is in flight
        lat = 3;
        do_reset();
        n = 0;
        while (req_log.size() == 0 && n < 10) begin step(); n++; end
        chk("t4 first_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h0);
        s_redirect = 1'b1; s_rpc = 32'h103;
        step();
        s_redirect = 1'b0;
        req_log.delete();
        xfer_log.delete();
        repeat (15) step();
        chk("t4 next_req", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h100);
        chk("t4 first_xfer", (xfer_log.size() > 0) ? xfer_log[0] : 32'hDEAD_BEEF, 32'h100);

        // redirect coincident with the response
        lat = 2;
        do_reset();
        n = 0;
        while (req_log.size() == 0 && n < 10) begin step(); n++; end
        step();
        s_redirect = 1'b1; s_rpc = 32'h200;
        step();
        s_redirect = 1'b0;
        req_log.delete();
        xfer_log.delete();
        step();
        chk("t5 inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("t5 imem_req", {31'b0, imem_req}, 32'h1);
        chk("t5 imem_addr", imem_addr, 32'h200);
        repeat (8) step();
        chk("t5 first_xfer", (xfer_log.size() > 0) ? xfer_log[0] : 32'hDEAD_BEEF, 32'h200);

        // RESET_PC at the top of the address space, then reset in S_WAIT
        step();
        chk("t6 rst req", {31'b0, imem_req2}, 32'h0);
        chk("t6 rst addr", imem_addr2, 32'hFFFF_FFFC);
        chk("t6 rst valid", {31'b0, inst_valid2}, 32'h0);
        chk("t6 rst inst", inst2, NOP);
        chk("t6 rst pc", inst_pc2, 32'hFFFF_FFFC);
        s_reset2 = 1'b0;
        step();
        chk("t6 req", {31'b0, imem_req2}, 32'h1);
        chk("t6 addr", imem_addr2, 32'hFFFF_FFFC);
        s_valid2 = 1'b1; s_rdata2 = 32'h0010_0093;
        step();
        s_valid2 = 1'b0;
        step();
        chk("t6 valid", {31'b0, inst_valid2}, 32'h1);
        chk("t6 pc", inst_pc2, 32'hFFFF_FFFC);
        chk("t6 inst", inst2, 32'h0010_0093);
        chk("t6 wrap req", {31'b0, imem_req2}, 32'h1);
        chk("t6 wrap addr", imem_addr2, 32'h0);
        s_reset2 = 1'b1;
        step();
        step();
        chk("t6 rerst req", {31'b0, imem_req2}, 32'h0);
        chk("t6 rerst addr", imem_addr2, 32'hFFFF_FFFC);
        chk("t6 rerst valid", {31'b0, inst_valid2}, 32'h0);
        chk("t6 rerst inst", inst2, NOP);
        chk("t6 rerst pc", inst_pc2, 32'hFFFF_FFFC);

        // random hold, latency and control flow against program order
        rand_mode = 1'b1; rand_lat = 1'b1; seed = $urandom;
        do_reset();
        exp_req = 32'h0; exp_x = 32'h0; blocked = 1'b0; rd_cnt = -1; rd_tgt = 32'h0;
        prev_hv = 1'b0; prev_inst = 32'h0; prev_pc = 32'h0; idle = 0; nx = 0;
        for (int c = 0; c < 4000; c++) begin
            s_hold = ($urandom_range(0, 3) == 0);
            s_redirect = 1'b0;
            if (rd_cnt == 0) begin
                s_redirect = 1'b1; s_rpc = rd_tgt;
                exp_req = {rd_tgt[31:2], 2'b00};
                blocked = 1'b0;
                rd_cnt = -1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
            end
            step();
            if (imem_req) begin
                chk("rnd req_while_blocked", {31'b0, blocked}, 32'h0);
                chk("rnd req_addr", imem_addr, exp_req);
                exp_req = exp_req + 32'd4;
            end
            if (imem_valid && is_cf(imem_rdata)) blocked = 1'b1;
            if (!inst_valid) chk("rnd nop", inst, NOP);
            if (prev_hv) begin
                chk("rnd hold_valid", {31'b0, inst_valid}, 32'h1);
                chk("rnd hold_inst", inst, prev_inst);
                chk("rnd hold_pc", inst_pc, prev_pc);
            end
            if (inst_valid && !hold) begin
                w = word_at(exp_x);
                chk("rnd xfer_pc", inst_pc, exp_x);
                chk("rnd xfer_inst", inst, w);
                if (is_cf(w)) begin
                    rd_tgt = $urandom;
                    rd_cnt = int'($urandom_range(0, 3));
                    exp_x  = {rd_tgt[31:2], 2'b00};
                end else begin
                    exp_x = exp_x + 32'd4;
                end
                idle = 0;
                nx++;
            end else begin
                idle++;
            end
            prev_hv = inst_valid && hold; prev_inst = inst; prev_pc = inst_pc;
            if (idle > 80) begin
                chk("rnd stall", 32'(idle), 32'd0);
                break;
            end
        end
        chk("rnd progress", {31'b0, nx >= 100}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
